pcie_dllp_tx_arbiter: RTL
=========================

# pcie_dllp_tx_arbiter

Packet-level arbiter that shares the single DLLP transmit AXI-stream toward the link layer framer among several DLLP sources: Ack/Nak, flow-control init, UpdateFC and power-management DLLPs. Requester 0 (Ack/Nak) has strict priority; the remaining requesters are served round-robin. An optional starvation watchdog can promote a waiting low-priority source over requester 0. A grant is held from the first beat to the `tlast` beat, so a DLLP body and its CRC beat are never interleaved with another source.

## Interface
- `DATA_WIDTH`, 32: per-beat data width.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width.
- `USER_WIDTH`, 3: tuser width.
- `NUM_REQ`, 4: number of requesters, 2..8; index 0 is the Ack/Nak source.
- `STARVE_LIMIT`, 64: watchdog threshold in cycles, 1..255.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `s_axis_tdata`  in  `NUM_REQ*DATA_WIDTH`  packed per requester; requester i occupies slice i.
- `s_axis_tkeep`  in  `NUM_REQ*KEEP_WIDTH`  per-requester tkeep.
- `s_axis_tvalid`  in  `NUM_REQ`  per-requester valid.
- `s_axis_tlast`  in  `NUM_REQ`  per-requester last.
- `s_axis_tuser`  in  `NUM_REQ*USER_WIDTH`  per-requester user.
- `s_axis_tready`  out  `NUM_REQ`  per-requester ready.
- `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`  out  widths as above  merged output stream.
- `m_axis_tready`  in  1  downstream ready.
- `grant_o`  out  `NUM_REQ`  one-hot current grant; zero when idle.
- `busy_o`  out  1  high while in `ST_XFER`.

## Operation
- FSM with two states, `ST_IDLE` and `ST_XFER`.
- `ST_IDLE`:
  - If any `s_axis_tvalid` is high, pick a winner and register it into `grant_r`, then go to `ST_XFER`.
  - If none is valid, stay in `ST_IDLE`.
- Pick order:
  1. A starving requester, with the lowest index winning (only when the watchdog is enabled).
  2. Requester 0.
  3. Round-robin over requesters 1..NUM_REQ-1, starting at `rr_ptr`.
- `ST_XFER`:
  - Output mux drives `m_axis_*` from the granted slice.
  - `s_axis_tready[g] = m_axis_tready`; all other `s_axis_tready` bits are 0.
  - On a beat with `m_axis_tvalid && m_axis_tready && m_axis_tlast`:
    - clear the grant and return to `ST_IDLE`;
    - if the granted index g is nonzero, set `rr_ptr` to the next index after g within 1..NUM_REQ-1, wrapping from NUM_REQ-1 back to 1;
    - a grant to requester 0 leaves `rr_ptr` unchanged.
- The granted source dropping `tvalid` mid-packet does not release the grant. The arbiter waits; there is no timeout.
- The grant is not re-evaluated in `ST_XFER`. A higher-priority request arriving mid-packet waits for `tlast`.
- When idle, `m_axis_*` outputs are all zero.

## Timing
- Arbitration costs exactly one bubble cycle: the request is seen in `ST_IDLE` at cycle N and the first beat can transfer at cycle N+1.
- Back-to-back packets therefore sustain at most 2 beats per 3 cycles for 2-beat DLLPs.
- Data path latency is 0 cycles: the output mux is combinational from the granted slice, and `tready` is combinational from `m_axis_tready`.
- Reset values:
  - state `ST_IDLE`, `grant_r` = 0, `rr_ptr` = 1, starvation counters = 0;
  - hence `m_axis_tvalid`=0, `m_axis_tdata`/`tkeep`/`tlast`/`tuser`=0, `s_axis_tready`=0, `grant_o`=0, `busy_o`=0.
- Reset asserted mid-packet aborts immediately (asynchronously). The partial packet is dropped; re-sending it is the source's responsibility.
- A single-beat packet (`tlast` on the first beat) is legal and returns the FSM to `ST_IDLE` after one beat.

## Configuration
- `PCIE_DLLP_ARB_STARVE_EN` defined:
  - 8-bit saturating counters exist for requesters 1..NUM_REQ-1.
  - A counter increments each cycle its `tvalid` is high and it is not granted.
  - It clears when that requester is granted.
  - At `STARVE_LIMIT` the requester is marked starving and outranks requester 0 at the next `ST_IDLE` pick.
- `PCIE_DLLP_ARB_STARVE_EN` undefined: no counters exist, and requester 0 has unconditional strict priority.

## Structure
- `pcie_datalink_pkg` holds:
  - `dllp_arb_state_e` (`ST_IDLE`, `ST_XFER`);
  - `DllpArbStarveLimitDefault` = 64;
  - `DllpArbAckNakIdx` = 0.
- One sub-module, `pcie_rr_arbiter`: a combinational round-robin pick.
  - Inputs: request vector and pointer.
  - Output: one-hot grant plus a valid flag.
  - Instantiated over requesters 1..NUM_REQ-1.

## Test plan
- **Single source:** req 2 sends a 2-beat DLLP with `m_axis_tready`=1.
  - `grant_o`=0b0100 from cycle 1.
  - Beats appear on cycles 1–2 with `tlast` on beat 2.
  - FSM is back in `ST_IDLE` at cycle 3, with `rr_ptr`=3.
- **Priority:** req 0 and req 1 are valid in the same cycle.
  - Req 0's packet goes out first; req 1 is granted after req 0's `tlast`.
  - Req 0 raising again mid-packet on req 1 does not preempt it.
- **Round-robin wrap:** with NUM_REQ=4, reqs 1, 2 and 3 stay continuously valid.
  - Grant order is 1, 2, 3, 1; `rr_ptr` wraps 3→1.
- **Backpressure:** `m_axis_tready` is held low for 5 cycles mid-packet.
  - Output beat held stable and the grant is kept.
  - `s_axis_tready` is 0 for every requester during the stall.
- **Starvation** (macro on, `STARVE_LIMIT`=8): req 0 is continuously valid and req 3 is valid.
  - Req 3 is granted at the first `ST_IDLE` after its counter reaches 8.
  - With the macro off, req 3 is never granted while req 0 stays valid.
- **Async reset mid-packet:** `rst_i` is pulsed after beat 1.
  - `m_axis_tvalid` falls in the same cycle.
  - `grant_o`=0, and the next grant follows normal pick order from `rr_ptr`=1.

Source files
------------

// File: rtl/pcie_datalink_pkg.sv
// Shared types and constants for the PCIe data-link-layer blocks.
package pcie_datalink_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } dllp_arb_state_e;

    localparam int DllpArbStarveLimitDefault = 64;
    localparam int DllpArbAckNakIdx          = 0;

    // Next round-robin pointer after serving index g; requester 0 is never in the ring.
    function automatic int dllp_rr_next(input int g, input int num_req);
        return (g >= num_req - 1) ? 1 : g + 1;
    endfunction

endpackage

// File: rtl/pcie_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr wins, wrapping at N.
module pcie_rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_dllp_tx_arbiter.sv
// Packet-level DLLP transmit arbiter: strict priority for Ack/Nak, round-robin for the rest.
// Optional starvation watchdog enabled by defining PCIE_DLLP_ARB_STARVE_EN.
module pcie_dllp_tx_arbiter
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 3,
    parameter int NUM_REQ      = 4,
    parameter int STARVE_LIMIT = DllpArbStarveLimitDefault,
    localparam int PTR_W       = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [NUM_REQ-1:0]             s_axis_tvalid,
    input  logic [NUM_REQ-1:0]             s_axis_tlast,
    input  logic [NUM_REQ*USER_WIDTH-1:0]  s_axis_tuser,
    output logic [NUM_REQ-1:0]             s_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           busy_o,
    output dllp_arb_state_e                dbg_state_o,
    output logic [PTR_W-1:0]               dbg_rr_ptr_o
);

    // Handshake: a beat moves when m_axis_tvalid && m_axis_tready; the granted source sees
    // tready equal to m_axis_tready, every other source sees 0, and the grant holds until tlast.

    if (NUM_REQ < 2 || NUM_REQ > 8 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
        $error("pcie_dllp_tx_arbiter: NUM_REQ or STARVE_LIMIT out of range");
    end

    dllp_arb_state_e      state;
    logic [NUM_REQ-1:0]   grant_r;
    logic [PTR_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   pick;
    logic                 pick_found;
    logic [NUM_REQ-2:0]   rr_grant;
    logic                 rr_valid;
    int                   grant_idx;
    logic                 last_beat;

    pcie_rr_arbiter #(
        .N     (NUM_REQ - 1),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (s_axis_tvalid[NUM_REQ-1:1]),
        .ptr   (rr_ptr - PTR_W'(1)),
        .grant (rr_grant),
        .valid (rr_valid)
    );

`ifdef PCIE_DLLP_ARB_STARVE_EN
    logic [7:0]         starve_cnt [1:NUM_REQ-1];
    logic [NUM_REQ-1:0] starving;

    // A source that reached the limit but has since dropped tvalid must not be picked,
    // otherwise the grant would sit on an idle source.
    always_comb begin
        starving = '0;
        for (int i = 1; i < NUM_REQ; i++) begin
            starving[i] = s_axis_tvalid[i] && (starve_cnt[i] >= 8'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 1; i < NUM_REQ; i++) starve_cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REQ; i++) begin
                if (state == ST_IDLE && pick[i]) begin
                    starve_cnt[i] <= '0;
                end else if (s_axis_tvalid[i] && !grant_r[i] && starve_cnt[i] != 8'hFF) begin
                    starve_cnt[i] <= starve_cnt[i] + 8'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
`ifdef PCIE_DLLP_ARB_STARVE_EN
        for (int i = 1; i < NUM_REQ; i++) begin
            if (!pick_found && starving[i]) begin
                pick[i]    = 1'b1;
                pick_found = 1'b1;
            end
        end
`endif
        if (!pick_found && s_axis_tvalid[DllpArbAckNakIdx]) begin
            pick[DllpArbAckNakIdx] = 1'b1;
            pick_found             = 1'b1;
        end
        if (!pick_found && rr_valid) begin
            pick = {rr_grant, 1'b0};
        end
    end

    // grant_r is zero outside ST_XFER, so the mux naturally drives zeros when idle.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        grant_idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_r[i]) begin
                m_axis_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tkeep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                m_axis_tuser  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                m_axis_tvalid = s_axis_tvalid[i];
                m_axis_tlast  = s_axis_tlast[i];
                grant_idx     = i;
            end
        end
    end

    assign s_axis_tready = grant_r & {NUM_REQ{m_axis_tready}};
    assign last_beat     = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            grant_r <= '0;
            rr_ptr  <= PTR_W'(1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_r <= pick;
                        state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (last_beat) begin
                        grant_r <= '0;
                        state   <= ST_IDLE;
                        if (grant_idx != DllpArbAckNakIdx) begin
                            rr_ptr <= PTR_W'(dllp_rr_next(grant_idx, NUM_REQ));
                        end
                    end
                end
                default: begin
                    grant_r <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_o      = grant_r;
    assign busy_o       = (state == ST_XFER);
    assign dbg_state_o  = state;
    assign dbg_rr_ptr_o = rr_ptr;

endmodule
